dvi_rx_tmds_decoder: RTL
========================

Name: dvi_rx_tmds_decoder

Overview:
- Receive-side counterpart of the DVI/TMDS transmit path. One instance per TMDS channel.
- Takes 10-bit parallel words from an external deserializer (ISERDES, pixel-clock domain) and finds word alignment by requesting bit-slips until control tokens appear.
- Decodes TMDS words back to 8-bit pixel data, DE, and C0/C1.
- Feeds the downstream DVI receive timing/recovery logic.

Parameters:
- TOKEN_COUNT, 8: consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 4096: cycles in SEARCH without lock before a bit-slip is requested.
- SLIP_WAIT, 16: settle cycles after a bit-slip pulse before searching resumes.
- LOCK_TIMEOUT, 65536: cycles in LOCKED with no control token before lock is dropped.

Ports:
- in_clk, input, 1: pixel clock; all logic on rising edge.
- in_reset_n, input, 1: asynchronous active-low reset.
- in_word, input, 10: deserialized TMDS word; bit 0 is the first bit on the wire.
- out_bitslip, output, 1: one-cycle pulse requesting the deserializer shift by one bit.
- out_aligned, output, 1: high while the FSM is in LOCKED.
- out_de, output, 1: data enable, 1 = data period.
- out_c0, output, 1: control bit 0.
- out_c1, output, 1: control bit 1.
- out_data, output, 8: decoded pixel byte.

Behaviour:
- Clocking and reset:
  - Single clock, in_clk; reset is asynchronous and active-low on in_reset_n.
  - Reset drives all outputs to 0 and the FSM to SEARCH with all counters at 0.
- Input and decode pipeline:
  - Stage 1 registers in_word. Stage 2 registers the decoded outputs.
  - Latency from in_word to outputs is exactly 2 cycles.
- Control tokens (decoded on the stage-1 word):
  - 10'h354 gives C1C0 = 00.
  - 10'h0AB gives C1C0 = 01.
  - 10'h154 gives C1C0 = 10.
  - 10'h2AB gives C1C0 = 11.
  - A token sets de=0, data=0 and c0/c1 from the table.
- Data word (any word that is not a token), with q = the stage-1 word:
  - de=1.
  - d = q[9] ? ~q[7:0] : q[7:0].
  - data[0] = d[0].
  - For i = 1..7: data[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
  - c0 and c1 hold their last control values.
- Output gating: while out_aligned=0, out_de, out_data, out_c0 and out_c1 are forced to 0. They become ungated the cycle after the FSM enters LOCKED.
- FSM, state SEARCH:
  - tok_cnt increments on each stage-1 token and clears on each non-token.
  - tok_cnt reaching TOKEN_COUNT moves to LOCKED. Lock takes priority if it coincides with the timeout.
  - search_cnt increments every cycle. Reaching SEARCH_TIMEOUT-1 without lock does the following:
    - out_bitslip=1 for exactly one cycle;
    - go to SLIP_WAIT;
    - clear tok_cnt and search_cnt.
- FSM, state SLIP_WAIT:
  - Counts SLIP_WAIT cycles while ignoring tokens, then returns to SEARCH with counters at 0.
  - out_bitslip is never re-asserted within SLIP_WAIT.
- FSM, state LOCKED:
  - out_aligned=1.
  - wd_cnt clears on every stage-1 token and otherwise increments.
  - wd_cnt reaching LOCK_TIMEOUT-1 returns to SEARCH: out_aligned drops the next cycle and counters clear.
  - Garbage data words alone never drop lock.
- Bit-slip cycling: slip requests repeat indefinitely, one per SEARCH_TIMEOUT+SLIP_WAIT period. The deserializer wraps its slip position modulo 10, so no slip counter is kept here.
- Counters: each counter is sized clog2(param)+1 and saturates at its limit; none may wrap.
- Reset mid-operation: asynchronous clear to SEARCH. An in-flight out_bitslip pulse is truncated.

Decomposition:
- Shared package dvi_pkg holds:
  - the four TMDS control-token localparams (10'h354, 10'h0AB, 10'h154, 10'h2AB);
  - the FSM state encoding (SEARCH, SLIP_WAIT, LOCKED).
- The transmit-side encoder uses the same token constants from dvi_pkg.
- One sub-module, tmds_decode_word: purely combinational 10b-to-(is_token, c[1:0], data[7:0]). The top module holds the pipeline registers and the alignment FSM.

Test Plan:
- Reset and lock:
  - Stimulus: hold in_reset_n=0, then release and feed 10'h354 continuously.
  - Required: all outputs 0 during reset; out_aligned rises after 8 tokens + 1 cycle; then out_de=0, c1c0=00, out_bitslip never pulses.
- Data decode, locked:
  - Stimulus: feed 10'h100, 10'h1FF, 10'h2FF, then 10'h2AB.
  - Required, 2 cycles later: (de=1, data 0x00), (de=1, data 0x01), (de=1, data 0xFE); the 10'h2AB gives de=0, c1c0=11.
- Misaligned stream:
  - Stimulus: 10'h354 rotated by 3 bits, small params (SEARCH_TIMEOUT=32, SLIP_WAIT=4); the bench model rotates by one bit per bit-slip pulse.
  - Required: exactly 7 bit-slip pulses spaced 36 cycles apart, then lock; no further pulses.
- Token run broken:
  - Stimulus: 7 tokens, 1 data word, 8 tokens.
  - Required: no lock after the first 7; lock after the second run.
- Lock loss:
  - Stimulus: lock, then LOCK_TIMEOUT=64 data words with no token.
  - Required: out_aligned drops after cycle 64; out_de/out_data forced to 0; search and slip cycling resumes.
- Async reset mid-slip:
  - Stimulus: assert in_reset_n=0 in the same cycle out_bitslip=1.
  - Required: out_bitslip goes low immediately (asynchronous); FSM in SEARCH with counters 0 after release.

Source files
------------

// File: rtl/dvi_pkg.sv
// dvi_pkg: TMDS control tokens and receive alignment states shared by the DVI TX/RX paths
package dvi_pkg;

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } align_state_e;

endpackage

// File: rtl/tmds_decode_word.sv
// tmds_decode_word: combinational TMDS 10b word to token flag, control pair and raw data byte
module tmds_decode_word (
    input  logic [9:0] in_word,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data
);
    import dvi_pkg::*;

    logic [7:0] d;

    // Undo the optional inversion, then undo the XOR/XNOR transition chain.
    always_comb begin
        d = in_word[9] ? ~in_word[7:0] : in_word[7:0];
        data[0] = d[0];
        for (int i = 1; i < 8; i++)
            data[i] = in_word[8] ? d[i] ^ d[i-1] : ~(d[i] ^ d[i-1]);
        is_token = (in_word == TOK_C00) || (in_word == TOK_C01) ||
                   (in_word == TOK_C10) || (in_word == TOK_C11);
        ctrl = (in_word == TOK_C01) ? 2'b01 :
               (in_word == TOK_C10) ? 2'b10 :
               (in_word == TOK_C11) ? 2'b11 : 2'b00;
    end

endmodule

// File: rtl/dvi_rx_tmds_decoder.sv
// dvi_rx_tmds_decoder: per-channel TMDS word alignment (bit-slip search) and 2-stage decode
module dvi_rx_tmds_decoder
    import dvi_pkg::*;
#(
    parameter int TOKEN_COUNT    = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16,
    parameter int LOCK_TIMEOUT   = 65536
) (
    input  logic       in_clk,
    input  logic       in_reset_n,
    input  logic [9:0] in_word,
    output logic       out_bitslip,
    output logic       out_aligned,
    output logic       out_de,
    output logic       out_c0,
    output logic       out_c1,
    output logic [7:0] out_data
);
    localparam int TOK_W  = $clog2(TOKEN_COUNT) + 1;
    localparam int SRCH_W = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;
    localparam int WD_W   = $clog2(LOCK_TIMEOUT) + 1;

    align_state_e      state_q, state_d;
    logic [TOK_W-1:0]  tok_q, tok_d;
    logic [SRCH_W-1:0] search_q, search_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              bitslip_q, bitslip_d;
    logic              aligned_q, aligned_d;
    logic [9:0]        word_q, word_d;
    logic [1:0]        c_q, c_d;
    logic              de_q, de_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        oc_q, oc_d;
    logic              is_tok, gate;
    logic [1:0]        dec_c;
    logic [7:0]        dec_data;

    tmds_decode_word u_dec (
        .in_word  (word_q),
        .is_token (is_tok),
        .ctrl     (dec_c),
        .data     (dec_data)
    );

    // Alignment FSM: count tokens to lock, time out into a slip, settle, and watch for lost lock.
    always_comb begin
        state_d   = state_q;
        tok_d     = tok_q;
        search_d  = search_q;
        wait_d    = wait_q;
        wd_d      = wd_q;
        bitslip_d = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                tok_d    = is_tok ? ((tok_q == TOK_W'(TOKEN_COUNT)) ? tok_q : tok_q + 1'b1) : '0;
                search_d = (search_q == SRCH_W'(SEARCH_TIMEOUT)) ? search_q : search_q + 1'b1;
                if (tok_d == TOK_W'(TOKEN_COUNT)) begin
                    state_d  = ST_LOCKED;
                    tok_d    = '0;
                    search_d = '0;
                    wd_d     = '0;
                end else if (search_q == SRCH_W'(SEARCH_TIMEOUT - 1)) begin
                    state_d   = ST_SLIP_WAIT;
                    bitslip_d = 1'b1;
                    tok_d     = '0;
                    search_d  = '0;
                    wait_d    = '0;
                end
            end
            ST_SLIP_WAIT: begin
                if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
                    state_d = ST_SEARCH;
                    wait_d  = '0;
                end else begin
                    wait_d = (wait_q == WAIT_W'(SLIP_WAIT)) ? wait_q : wait_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (is_tok) begin
                    wd_d = '0;
                end else if (wd_q == WD_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = ST_SEARCH;
                    wd_d    = '0;
                end else begin
                    wd_d = (wd_q == WD_W'(LOCK_TIMEOUT)) ? wd_q : wd_q + 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Decode datapath: outputs stay zero unless the channel was locked before and after this edge.
    always_comb begin
        word_d    = in_word;
        aligned_d = (state_d == ST_LOCKED);
        gate      = aligned_q & aligned_d;
        c_d       = is_tok ? dec_c : c_q;
        de_d      = gate & ~is_tok;
        data_d    = de_d ? dec_data : 8'h00;
        oc_d      = gate ? c_d : 2'b00;
    end

    // State and pipeline registers, cleared asynchronously.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q   <= ST_SEARCH;
            tok_q     <= '0;
            search_q  <= '0;
            wait_q    <= '0;
            wd_q      <= '0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
            word_q    <= '0;
            c_q       <= '0;
            de_q      <= 1'b0;
            data_q    <= '0;
            oc_q      <= '0;
        end else begin
            state_q   <= state_d;
            tok_q     <= tok_d;
            search_q  <= search_d;
            wait_q    <= wait_d;
            wd_q      <= wd_d;
            bitslip_q <= bitslip_d;
            aligned_q <= aligned_d;
            word_q    <= word_d;
            c_q       <= c_d;
            de_q      <= de_d;
            data_q    <= data_d;
            oc_q      <= oc_d;
        end
    end

    assign out_bitslip = bitslip_q;
    assign out_aligned = aligned_q;
    assign out_de      = de_q;
    assign out_data    = data_q;
    assign out_c0      = oc_q[0];
    assign out_c1      = oc_q[1];

endmodule
